// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel pipeline.
package sobel_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ROWS       = 5;
  localparam int COLS       = 6;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_delay.sv
// One image row of storage: sync write, same-address
// combinational read so the old value is seen first.
module sobel_line_delay
  import sobel_pkg::*;
#(
  parameter int DEPTH = COLS,
  parameter int DW    = DATA_WIDTH,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_line_buffer.sv
// Raster stream to vertical column triples (rows r-2, r-1, r)
// using two row memories that shift one row per valid beat.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int ROWS       = sobel_pkg::ROWS,
  parameter int COLS       = sobel_pkg::COLS,
  parameter int DATA_WIDTH = sobel_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  done_i,
  output logic [DATA_WIDTH-1:0] d0_o,
  output logic [DATA_WIDTH-1:0] d1_o,
  output logic [DATA_WIDTH-1:0] d2_o,
  output logic                  done_o,
  output logic                  frame_done_o
);

  localparam int CW = cnt_w(COLS);
  localparam int RW = cnt_w(ROWS);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_col, last_row, we;

  logic [DATA_WIDTH-1:0] a, b;
  logic [DATA_WIDTH-1:0] d0_q, d1_q, d2_q;
  logic                  done_q, fdone_q;

  assign last_col = (col_q == CW'(COLS-1));
  assign last_row = (row_q == RW'(ROWS-1));
  assign we       = done_i && !rst;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (done_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  sobel_line_delay #(
    .DEPTH(COLS), .DW(DATA_WIDTH), .AW(CW)
  ) u_line0 (
    .clk(clk), .we_i(we), .addr_i(col_q),
    .wdata_i(b), .rdata_o(a)
  );

  sobel_line_delay #(
    .DEPTH(COLS), .DW(DATA_WIDTH), .AW(CW)
  ) u_line1 (
    .clk(clk), .we_i(we), .addr_i(col_q),
    .wdata_i(data_i), .rdata_o(b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      done_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_i && (row_q >= RW'(2));
      fdone_q <= done_i && last_row && last_col;
      // data regs hold across gaps so downstream sees stable values
      if (done_i) begin
        d0_q <= a;
        d1_q <= b;
        d2_q <= data_i;
      end
    end
  end

  assign d0_o         = d0_q;
  assign d1_o         = d1_q;
  assign d2_o         = d2_q;
  assign done_o       = done_q;
  assign frame_done_o = fdone_q;

endmodule

// File: tb/tb_sobel_line_buffer.sv
// Self-checking bench: image-array reference model, directed
// frames plus random data and random gaps.
module tb_sobel_line_buffer;

  localparam int R = 5;
  localparam int C = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       done_i;
  logic [7:0] d0_o, d1_o, d2_o;
  logic       done_o, frame_done_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [R][C];
  int         mr, mc;
  logic [7:0] e0, e1, e2;
  logic       edone, efd;
  int         npulse, nfd;
  logic [7:0] f0, f1, f2;
  logic       got_first;

  always #5 clk = ~clk;

  sobel_line_buffer #(.ROWS(R), .COLS(C), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .done_i(done_i),
    .d0_o(d0_o), .d1_o(d1_o), .d2_o(d2_o),
    .done_o(done_o), .frame_done_o(frame_done_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    npulse = 0;
    nfd = 0;
    got_first = 1'b0;
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [7:0] d);
    rst = r;
    done_i = v;
    data_i = d;
    @(posedge clk);
    #1;
    if (r) begin
      {e0, e1, e2, edone, efd} = '0;
      mr = 0;
      mc = 0;
    end else if (v) begin
      edone = (mr >= 2);
      efd = (mr == R-1) && (mc == C-1);
      // after a reset the row memories hold stale data until rows 0,1
      if (mr >= 2) begin
        e0 = img[mr-2][mc];
        e1 = img[mr-1][mc];
      end else begin
        e0 = dut.d0_o;
        e1 = dut.d1_o;
      end
      e2 = d;
      img[mr][mc] = d;
      if (mc == C-1) begin
        mc = 0;
        mr = (mr == R-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end else begin
      edone = 1'b0;
      efd = 1'b0;
    end
    chk("done_o", done_o, edone);
    chk("frame_done_o", frame_done_o, efd);
    if (edone || r) begin
      chk("d0_o", d0_o, e0);
      chk("d1_o", d1_o, e1);
      chk("d2_o", d2_o, e2);
    end
    if (done_o) begin
      npulse++;
      if (!got_first) begin
        got_first = 1'b1;
        {f0, f1, f2} = {d0_o, d1_o, d2_o};
      end
    end
    if (frame_done_o) nfd++;
  endtask

  initial begin
    rst = 1'b1;
    done_i = 1'b0;
    data_i = '0;
    mr = 0;
    mc = 0;

    // reset held with a valid 0xFF beat pending
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF);

    // continuous frame, pixel = raster index
    clr_stats();
    for (int i = 0; i < R*C; i++) step(1'b0, 1'b1, 8'(i));
    step(1'b0, 1'b0, 8'h00);
    chk("cont_pulses", npulse, 18);
    chk("cont_fdone", nfd, 1);
    chk("cont_first", {f0, f1, f2}, {8'd0, 8'd6, 8'd12});
    chk("cont_last", {d0_o, d1_o, d2_o}, {8'd17, 8'd23, 8'd29});

    // gapped stream, valid every other cycle
    clr_stats();
    for (int i = 0; i < R*C; i++) begin
      step(1'b0, 1'b1, 8'(i));
      step(1'b0, 1'b0, 8'hAA);
    end
    chk("gap_pulses", npulse, 18);
    chk("gap_first", {f0, f1, f2}, {8'd0, 8'd6, 8'd12});

    // back-to-back frames with no idle cycle
    clr_stats();
    for (int i = 0; i < R*C; i++) step(1'b0, 1'b1, 8'(i));
    got_first = 1'b0;
    for (int i = 0; i < R*C; i++) step(1'b0, 1'b1, 8'(100+i));
    chk("b2b_pulses", npulse, 36);
    chk("b2b_fdone", nfd, 2);
    chk("b2b_first2", {f0, f1, f2}, {8'd100, 8'd106, 8'd112});

    // reset after index 15, then restart
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(50+i));
    step(1'b1, 1'b0, 8'h00);
    clr_stats();
    for (int i = 0; i < R*C; i++) step(1'b0, 1'b1, 8'(i));
    chk("rst_pulses", npulse, 18);
    chk("rst_first", {f0, f1, f2}, {8'd0, 8'd6, 8'd12});

    // random data and random gaps across several frames
    clr_stats();
    for (int f = 0; f < 4; f++) begin
      int n;
      n = 0;
      while (n < R*C) begin
        logic v;
        v = ($urandom_range(3) != 0);
        step(1'b0, v, 8'($urandom));
        if (v) n++;
      end
    end
    step(1'b0, 1'b0, 8'h00);
    chk("rnd_pulses", npulse, 4*18);
    chk("rnd_fdone", nfd, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
